result_unloader: RTL
====================

// Module: result_unloader
// PURPOSE
//  Output-side counterpart of the DIP-switch instruction loader. Takes one DATA_W-bit
//  result from the execute stage (valid/ready handshake), then shows it on the 8 LEDs
//  one byte at a time, LSB byte first, stepping on each debounced push-button press.
//  Contains its own button synchronizer, debouncer and rising-edge detector.
// PARAMETERS
//  DATA_W           16  result width; multiple of 8, >= 16; NBYTES = DATA_W/8
//  DEBOUNCE_CYCLES  16  consecutive stable cycles before a button level is accepted (>= 1)
// PORTS
//  clk        in   1         system clock; all state on rising edge
//  rst        in   1         async reset, active-high
//  btn_in     in   1         raw push button, 1 = pressed, asynchronous to clk
//  res_valid  in   1         execute stage offers a result
//  res_data   in   DATA_W    result word, sampled on handshake
//  res_ready  out  1         unloader can accept a result
//  led_out    out  8         byte currently displayed
//  byte_idx   out  clog2(NBYTES)  index of displayed byte (0 = LSB byte)
//  busy       out  1         result captured and still being displayed
//  done       out  1         1-cycle pulse when the last byte is stepped past
// BEHAVIOUR
//  Async reset values: res_ready=1, led_out=0, byte_idx=0, busy=0, done=0; state=S_IDLE;
//   sync flops, debounced level, edge history and counter = 0; captured word discarded.
//  Button path: 2-flop synchronizer -> s. Debouncer keeps level deb and counter cnt:
//   s==deb -> cnt<=0; s!=deb -> cnt<=cnt+1; when s!=deb and cnt==DEBOUNCE_CYCLES-1,
//   deb<=s and cnt<=0. Glitches shorter than DEBOUNCE_CYCLES cycles never change deb.
//   step = deb & ~deb_q (deb_q = deb delayed 1 cycle): one pulse per press, none on release.
//   Latency from raw edge to step = 2 + DEBOUNCE_CYCLES cycles.
//  FSM (2 states):
//   S_IDLE: res_ready=1, busy=0, led_out=0. step is ignored. On res_valid & res_ready:
//    latch res_data, byte_idx<=0, -> S_SHOW; next cycle led_out=res_data[7:0], busy=1,
//    res_ready=0.
//   S_SHOW: res_ready=0; led_out = captured byte[byte_idx] (registered).
//    step & byte_idx<NBYTES-1 -> byte_idx+1, led_out = next byte the following cycle.
//    step & byte_idx==NBYTES-1 -> done=1 for that following cycle, led_out<=0,
//    byte_idx<=0, busy<=0, -> S_IDLE (res_ready=1 in the same cycle done is 1).
//  res_data changes while in S_SHOW have no effect; no new capture until back in S_IDLE.
//  Button held through a capture: no step until released and pressed again.
//  Reset mid-display: immediate return to reset values; no done pulse.
//  Button held at reset release: deb rises after debounce, step fires in S_IDLE, ignored.
// TESTING (DEBOUNCE_CYCLES=4, DATA_W=16)
//  1 Reset, res_valid=1 res_data=16'hA53C -> next cycle led_out=8'h3C, busy=1,
//    res_ready=0, byte_idx=0.
//  2 Press btn 20 cycles -> exactly one step 6 cycles after press; led_out=8'hA5,
//    byte_idx=1; release produces no step.
//  3 Second press -> done pulses 1 cycle, led_out=0, res_ready=1, busy=0.
//  4 Bounce: btn toggles every 2 cycles for 30 cycles, then stays low -> no step,
//    led_out unchanged.
//  5 Press in S_IDLE with res_valid=0 -> no state change; then res_valid=1
//    res_data=16'h00FF -> led_out=8'hFF.
//  6 Assert rst while byte_idx=1 -> all outputs at reset values asynchronously; done=0.

Source files
------------

// File: rtl/result_unloader.sv
// Holds one execute-stage result and shows it byte by byte on the LEDs, LSB byte first, one byte per debounced button press.
// Latency: the first byte shows 1 cycle after capture; a raw press steps the display 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: res_ready is low from capture until the last byte is stepped past.
module result_unloader #(
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int NBYTES         = DATA_W / 8,
    localparam int IDX_W          = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic [7:0]        led_out,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_SHOW
    } state_t;

    state_t             state, state_nxt;
    logic               sync1, sync2;
    logic               deb, deb_q;
    logic [CNT_W-1:0]   cnt;
    logic               step;
    logic [DATA_W-1:0]  cap, cap_nxt;
    logic [7:0]         led_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               busy_nxt, done_nxt;

    // btn_in is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            deb_q <= deb;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign step      = deb & ~deb_q;
    assign res_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cap      <= '0;
            led_out  <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cap      <= cap_nxt;
            led_out  <= led_nxt;
            byte_idx <= idx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // cap is shifted right on each step so the next byte is always cap[15:8]
    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        led_nxt   = led_out;
        idx_nxt   = byte_idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (res_valid) begin
                    cap_nxt   = res_data;
                    led_nxt   = res_data[7:0];
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (step) begin
                    if (byte_idx == IDX_W'(NBYTES - 1)) begin
                        led_nxt   = '0;
                        idx_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cap_nxt = cap >> 8;
                        led_nxt = cap[15:8];
                        idx_nxt = byte_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
